// File: rtl/latch_bank.sv
// Bank of independent data latches with follow / capture-once modes.
// Each channel tracks its captures with a sticky change flag and a saturating count.
module latch_bank #(
  parameter int               WIDTH    = 8,
  parameter int               CHANNELS = 4,
  parameter int               CNT_W    = 4,
  parameter logic [WIDTH-1:0] RST_VAL  = '0
) (
  input  logic                      clk,
  input  logic                      rstn,
  input  logic                      mode,
  input  logic [CHANNELS-1:0]       en,
  input  logic [CHANNELS*WIDTH-1:0] d,
  input  logic [CHANNELS-1:0]       clr,
  output logic [CHANNELS*WIDTH-1:0] q,
  output logic [CHANNELS-1:0]       locked,
  output logic [CHANNELS-1:0]       changed,
  output logic [CHANNELS*CNT_W-1:0] cap_cnt
);

  typedef enum logic {
    OPEN   = 1'b0,
    LOCKED = 1'b1
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  generate
    for (genvar gi = 0; gi < CHANNELS; gi++) begin : g_ch
      state_t           state_reg, state_next;
      logic [WIDTH-1:0] q_reg, q_next;
      logic             changed_reg, changed_next;
      logic [CNT_W-1:0] cnt_reg, cnt_next;
      logic [WIDTH-1:0] d_c;

      assign d_c = d[gi*WIDTH +: WIDTH];

      // clr beats everything; a LOCKED channel only reacts to mode falling back to 0
      always_comb begin
        state_next   = state_reg;
        q_next       = q_reg;
        changed_next = changed_reg;
        cnt_next     = cnt_reg;
        if (clr[gi]) begin
          state_next   = OPEN;
          changed_next = 1'b0;
          cnt_next     = '0;
        end else if (state_reg == LOCKED) begin
          if (!mode) state_next = OPEN;
        end else if (en[gi]) begin
          q_next = d_c;
          if (d_c != q_reg) changed_next = 1'b1;
          if (cnt_reg != CNT_MAX) cnt_next = cnt_reg + 1'b1;
          if (mode) state_next = LOCKED;
        end
      end

      always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
          state_reg   <= OPEN;
          q_reg       <= RST_VAL;
          changed_reg <= 1'b0;
          cnt_reg     <= '0;
        end else begin
          state_reg   <= state_next;
          q_reg       <= q_next;
          changed_reg <= changed_next;
          cnt_reg     <= cnt_next;
        end
      end

      assign q[gi*WIDTH +: WIDTH]       = q_reg;
      assign locked[gi]                 = (state_reg == LOCKED);
      assign changed[gi]                = changed_reg;
      assign cap_cnt[gi*CNT_W +: CNT_W] = cnt_reg;
    end
  endgenerate

endmodule

// File: tb/tb_latch_bank.sv
// Directed bench for latch_bank: per-channel behavioural model plus literal checkpoints.
module tb_latch_bank;

  localparam int W = 8;
  localparam int C = 4;
  localparam int N = 4;

  logic           clk = 1'b0;
  logic           rstn;
  logic           mode;
  logic [C-1:0]   en;
  logic [C*W-1:0] d;
  logic [C-1:0]   clr;
  logic [C*W-1:0] q;
  logic [C-1:0]   locked;
  logic [C-1:0]   changed;
  logic [C*N-1:0] cap_cnt;

  int vectors = 0;
  int miscompares = 0;

  // model state: plain per-channel arrays
  int m_q   [C];
  bit m_lock[C];
  bit m_chg [C];
  int m_cnt [C];

  latch_bank #(.WIDTH(W), .CHANNELS(C), .CNT_W(N), .RST_VAL('0)) dut (
    .clk(clk), .rstn(rstn), .mode(mode), .en(en), .d(d), .clr(clr),
    .q(q), .locked(locked), .changed(changed), .cap_cnt(cap_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int c = 0; c < C; c++) begin
        m_q[c] = 0; m_lock[c] = 0; m_chg[c] = 0; m_cnt[c] = 0;
      end
    end else begin
      for (int c = 0; c < C; c++) begin
        int dv;
        dv = int'(d[c*W +: W]);
        if (clr[c]) begin
          m_lock[c] = 0; m_chg[c] = 0; m_cnt[c] = 0;
        end else if (m_lock[c]) begin
          if (!mode) m_lock[c] = 0;
        end else if (en[c]) begin
          if (dv != m_q[c]) m_chg[c] = 1;
          m_q[c] = dv;
          m_cnt[c] = (m_cnt[c] >= 15) ? 15 : m_cnt[c] + 1;
          m_lock[c] = mode;
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic compare_all();
    for (int c = 0; c < C; c++) begin
      chk($sformatf("q%0d", c),       32'(q[c*W +: W]),       32'(m_q[c]));
      chk($sformatf("locked%0d", c),  32'(locked[c]),         32'(m_lock[c]));
      chk($sformatf("changed%0d", c), 32'(changed[c]),        32'(m_chg[c]));
      chk($sformatf("cap_cnt%0d", c), 32'(cap_cnt[c*N +: N]), 32'(m_cnt[c]));
    end
    $display("t=%0t mode=%b en=%h clr=%h d=%h -> q=%h locked=%h changed=%h cap_cnt=%h",
             $time, mode, en, clr, d, q, locked, changed, cap_cnt);
  endtask

  // one rising edge, then check on the following falling edge
  task automatic step();
    @(posedge clk);
    @(negedge clk);
    compare_all();
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_q"},       32'(q),       32'h0);
    chk({tag, "_locked"},  32'(locked),  32'h0);
    chk({tag, "_changed"}, 32'(changed), 32'h0);
    chk({tag, "_cap_cnt"}, 32'(cap_cnt), 32'h0);
  endtask

  initial begin
    rstn = 1'b1; mode = 1'b0; en = 4'hF; d = 32'hA5A5A5A5; clr = 4'h0;
    // async reset with no clock edge
    #1 rstn = 1'b0;
    #1 check_reset_vals("rst_async");
    compare_all();
    step();
    step();
    rstn = 1'b1; en = 4'h0;

    // follow mode on channel 0
    mode = 1'b0; en = 4'b0001;
    d[0 +: W] = 8'h11; step(); chk("follow_q0_a", 32'(q[0 +: W]), 32'h11);
    d[0 +: W] = 8'h22; step(); chk("follow_q0_b", 32'(q[0 +: W]), 32'h22);
    d[0 +: W] = 8'h33; step(); chk("follow_q0_c", 32'(q[0 +: W]), 32'h33);
    chk("follow_locked0", 32'(locked[0]), 32'h0);
    chk("follow_changed0", 32'(changed[0]), 32'h1);
    chk("follow_cnt0", 32'(cap_cnt[0 +: N]), 32'd3);

    // capture-once on channel 1
    mode = 1'b1; en = 4'b0010;
    d[W +: W] = 8'h3C; step();
    chk("once_q1", 32'(q[W +: W]), 32'h3C);
    chk("once_locked1", 32'(locked[1]), 32'h1);
    chk("once_cnt1", 32'(cap_cnt[N +: N]), 32'd1);
    d[W +: W] = 8'h7E; step();
    chk("once_hold_q1", 32'(q[W +: W]), 32'h3C);
    en = 4'b0000; clr = 4'b0010; step();
    chk("clr_locked1", 32'(locked[1]), 32'h0);
    chk("clr_changed1", 32'(changed[1]), 32'h0);
    chk("clr_cnt1", 32'(cap_cnt[N +: N]), 32'd0);
    chk("clr_q1", 32'(q[W +: W]), 32'h3C);

    // clr beats en on ch2; ch0 captures independently in the same edge
    clr = 4'b0100; en = 4'b0101;
    d[2*W +: W] = 8'hFF; d[0 +: W] = 8'h44; step();
    chk("prio_q2", 32'(q[2*W +: W]), 32'h00);
    chk("prio_locked2", 32'(locked[2]), 32'h0);
    chk("prio_cnt2", 32'(cap_cnt[2*N +: N]), 32'd0);
    chk("indep_q0", 32'(q[0 +: W]), 32'h44);
    chk("indep_locked0", 32'(locked[0]), 32'h1);
    clr = 4'b0000;

    // saturation with constant zero data on ch3
    mode = 1'b0; en = 4'b1000; d[3*W +: W] = 8'h00;
    for (int i = 1; i <= 20; i++) begin
      step();
      if (i == 15) chk("sat_cnt3_15", 32'(cap_cnt[3*N +: N]), 32'd15);
    end
    chk("sat_cnt3_20", 32'(cap_cnt[3*N +: N]), 32'd15);
    chk("sat_changed3", 32'(changed[3]), 32'h0);

    // lock ch0, drop mode, then reset between edges
    mode = 1'b1; en = 4'b0001; d[0 +: W] = 8'h5A; step();
    chk("mo_locked0", 32'(locked[0]), 32'h1);
    chk("mo_q0", 32'(q[0 +: W]), 32'h5A);
    mode = 1'b0; d[0 +: W] = 8'h77; step();
    chk("mo_unlock0", 32'(locked[0]), 32'h0);
    chk("mo_nocap_q0", 32'(q[0 +: W]), 32'h5A);
    mode = 1'b1; d[0 +: W] = 8'h66; step();
    chk("mo_relock_q0", 32'(q[0 +: W]), 32'h66);
    #2 rstn = 1'b0;
    #1 check_reset_vals("rst_midop");
    compare_all();
    step();
    rstn = 1'b1; mode = 1'b0; en = 4'b0001; d[0 +: W] = 8'h99; step();
    chk("post_rst_q0", 32'(q[0 +: W]), 32'h99);
    chk("post_rst_cnt0", 32'(cap_cnt[0 +: N]), 32'd1);

    // mixed traffic across all channels, checked against the model
    for (int i = 0; i < 60; i++) begin
      mode = (i % 12) < 7;
      en   = 4'($urandom_range(0, 15));
      clr  = ((i % 9) == 4) ? 4'($urandom_range(0, 15)) : 4'h0;
      d    = {8'($urandom_range(0, 3)), 8'($urandom), 8'($urandom_range(0, 1)), 8'($urandom)};
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
